// File: rtl/regfile_mp_if.sv
// regfile_mp_if -- bus bundle for the regfile_mp register file.
// Groups the write port, the packed read ports and the bulk-clear
// handshake. clk/reset stay as plain ports on the module.
//   master : decode/writeback side (drives addresses, data, clr_req)
//   slave  : register file (drives rdata, clr_busy, clr_done, wr_drop)
// With REGFILE_PARITY_EN defined, a per-read-port par_err vector is added.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
);
  localparam int NB = DATA_W / 8;

  logic                    we;
  logic [ADDR_W-1:0]       waddr;
  logic [DATA_W-1:0]       wdata;
  logic [NB-1:0]           wbe;
  logic [NRD*ADDR_W-1:0]   raddr;
  logic [NRD*DATA_W-1:0]   rdata;
  logic                    clr_req;
  logic                    clr_busy;
  logic                    clr_done;
  logic                    wr_drop;
`ifdef REGFILE_PARITY_EN
  logic [NRD-1:0]          par_err;

  modport master (
    output we, waddr, wdata, wbe, raddr, clr_req,
    input  rdata, clr_busy, clr_done, wr_drop, par_err
  );
  modport slave (
    input  we, waddr, wdata, wbe, raddr, clr_req,
    output rdata, clr_busy, clr_done, wr_drop, par_err
  );
`else
  modport master (
    output we, waddr, wdata, wbe, raddr, clr_req,
    input  rdata, clr_busy, clr_done, wr_drop
  );
  modport slave (
    input  we, waddr, wdata, wbe, raddr, clr_req,
    output rdata, clr_busy, clr_done, wr_drop
  );
`endif
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised multi-read-port register file.
//   DATA_W x 2**ADDR_W entries, NRD combinational read ports, one
//   byte-masked write port with same-cycle write-to-read bypass, and a
//   one-entry-per-cycle bulk-clear engine (IDLE/CLEAR) with busy/done.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (clears every entry)
//   bus   : regfile_mp_if.slave (we/waddr/wdata/wbe, raddr/rdata,
//           clr_req/clr_busy/clr_done, wr_drop[, par_err])
// Optional feature macro: REGFILE_PARITY_EN -- adds one even-parity bit
//   per stored byte and the par_err[NRD] output.
// The interface instance must be built with the same DATA_W/ADDR_W/NRD.

// One read lane: zero-register, bypass and kill (reset/clear) selection.
module regfile_mp_rdport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0]   raddr,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic                byp_en,   // write in progress and FSM idle
  input  logic                kill,     // reset held or clear running
  input  logic [DATA_W-1:0]   wmerge,   // stored word merged with wdata/wbe
  input  logic [DATA_W-1:0]   stored,
`ifdef REGFILE_PARITY_EN
  input  logic [DATA_W/8-1:0] stored_par,
  output logic                par_err,
`endif
  output logic [DATA_W-1:0]   rdata
);
  logic zero_hit, byp_hit;

  assign zero_hit = (ZERO_REG != 0) && (raddr == '0);
  assign byp_hit  = byp_en && (raddr == waddr);

  always_comb begin
    rdata = stored;
    if (kill || zero_hit) rdata = '0;
    else if (byp_hit)     rdata = wmerge;
  end

`ifdef REGFILE_PARITY_EN
  // Only a word actually coming out of storage can flag an error.
  logic bad;
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DATA_W/8; i++)
      bad = bad | ((^stored[8*i +: 8]) != stored_par[i]);
    par_err = bad && !kill && !zero_hit && !byp_hit;
  end
`endif
endmodule

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        reset,
  regfile_mp_if.slave bus
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                      state, state_n;
  logic [ADDR_W-1:0]           ptr, ptr_n;
  logic                        clr_done, done_n;
  logic                        wr_drop, drop_n;
  logic                        clr_we;
  logic                        idle, wr_en;
  logic [DATA_W-1:0]           wmerge;
  logic [DEPTH-1:0][DATA_W-1:0] mem;

  assign idle = (state == IDLE);

  // Entry 0 is never written when it is the hardwired zero register.
  assign wr_en = bus.we && idle && !((ZERO_REG != 0) && (bus.waddr == '0));

  // Byte-masked merge, shared by the write path and the read bypass.
  always_comb begin
    wmerge = mem[bus.waddr];
    for (int i = 0; i < NB; i++)
      if (bus.wbe[i]) wmerge[8*i +: 8] = bus.wdata[8*i +: 8];
  end

  // Clear FSM: next state / outputs.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    done_n  = 1'b0;
    drop_n  = 1'b0;
    clr_we  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.clr_req) begin
          state_n = CLEAR;
          ptr_n   = '0;
        end
      end
      CLEAR: begin
        clr_we = 1'b1;
        drop_n = bus.we;            // writes are discarded while clearing
        ptr_n  = ptr + 1'b1;        // wraps to 0 after the last entry
        if (ptr == '1) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      clr_done <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      clr_done <= done_n;
      wr_drop  <= drop_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       mem <= '0;
    else if (clr_we) mem[ptr] <= '0;
    else if (wr_en)  mem[bus.waddr] <= wmerge;
  end

`ifdef REGFILE_PARITY_EN
  logic [DEPTH-1:0][NB-1:0] par_mem;
  logic [NB-1:0]            wpar;
  logic [NRD-1:0]           pe;

  always_comb
    for (int i = 0; i < NB; i++) wpar[i] = ^wmerge[8*i +: 8];

  // A zeroed byte has even parity 0, so cleared entries stay consistent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       par_mem <= '0;
    else if (clr_we) par_mem[ptr] <= '0;
    else if (wr_en)  par_mem[bus.waddr] <= wpar;
  end

  assign bus.par_err = pe;
`endif

  assign bus.clr_busy = (state == CLEAR);
  assign bus.clr_done = clr_done;
  assign bus.wr_drop  = wr_drop;

  // Read lanes.
  logic [NRD-1:0][ADDR_W-1:0] ra;
  logic [NRD-1:0][DATA_W-1:0] rd;
  logic                       kill, byp_en;

  assign ra        = bus.raddr;
  assign bus.rdata = rd;
  assign kill      = reset || !idle;
  assign byp_en    = bus.we && idle;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_mp_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .raddr      (ra[k]),
      .waddr      (bus.waddr),
      .byp_en     (byp_en),
      .kill       (kill),
      .wmerge     (wmerge),
      .stored     (mem[ra[k]]),
`ifdef REGFILE_PARITY_EN
      .stored_par (par_mem[ra[k]]),
      .par_err    (pe[k]),
`endif
      .rdata      (rd[k])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- self-checking bench for regfile_mp (DATA_W=32,
// ADDR_W=5, NRD=2, ZERO_REG=1). A behavioural model (array of words,
// a busy flag and a remaining-cycle count for the clear) predicts read
// data and the clr_busy/clr_done/wr_drop outputs every cycle.
module tb_regfile_mp;
  localparam int DW = 32, AW = 5, NRD = 2, DEPTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) bus();
  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_cmp = 0, n_err = 0;

  logic [31:0] m_mem [DEPTH];
  bit m_busy, m_done, m_drop;
  int m_left;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(int k);
    logic [4:0] a;
    a = bus.raddr[k*AW +: AW];
    if (reset || m_busy) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (bus.we && a == bus.waddr) return merge(m_mem[a], bus.wdata, bus.wbe);
    return m_mem[a];
  endfunction

  task automatic model_reset();
    foreach (m_mem[i]) m_mem[i] = 32'h0;
    m_busy = 0; m_done = 0; m_drop = 0; m_left = 0;
  endtask

  // Clear is modelled as "busy for DEPTH cycles, then everything is 0";
  // reads are 0 and writes dropped meanwhile, so the order is invisible.
  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else begin
      m_done = 0; m_drop = 0;
      if (!m_busy) begin
        if (bus.we && bus.waddr != 5'd0)
          m_mem[bus.waddr] = merge(m_mem[bus.waddr], bus.wdata, bus.wbe);
        if (bus.clr_req) begin m_busy = 1; m_left = DEPTH; end
      end else begin
        m_drop = bus.we;
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1;
          foreach (m_mem[i]) m_mem[i] = 32'h0;
        end
      end
    end
  endtask

  task automatic set_in(logic we, logic [4:0] wa, logic [31:0] wd, logic [3:0] be,
                        logic [4:0] r0, logic [4:0] r1, logic cr);
    bus.we = we; bus.waddr = wa; bus.wdata = wd; bus.wbe = be;
    bus.raddr = {r1, r0}; bus.clr_req = cr;
  endtask

  // Inputs are set just after a falling edge; check reads, clock, check flags.
  task automatic tick();
    #1;
    chk("rdata0", bus.rdata[31:0],  exp_rd(0));
    chk("rdata1", bus.rdata[63:32], exp_rd(1));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("clr_busy", {31'b0, bus.clr_busy}, {31'b0, m_busy});
    chk("clr_done", {31'b0, bus.clr_done}, {31'b0, m_done});
    chk("wr_drop",  {31'b0, bus.wr_drop},  {31'b0, m_drop});
  endtask

  task automatic sweep();
    for (int a = 0; a < DEPTH; a += 2) begin
      set_in(0, 5'd0, 32'h0, 4'h0, 5'(a), 5'(a + 1), 0);
      tick();
    end
  endtask

  task automatic fill();
    for (int a = 1; a < DEPTH; a++) begin
      set_in(1, 5'(a), 32'hA500_0000 | 32'(a), 4'hF, 5'(a), 5'($urandom), 0);
      tick();
    end
  endtask

  // Starts a clear. drop_at: busy-cycle index that issues a write to r9;
  // reset_at: busy-cycle index at which reset is asserted (-1 = never).
  task automatic run_clear(input int drop_at, input int reset_at,
                           output int busy_n, output int done_n, output int drop_n);
    busy_n = 0; done_n = 0; drop_n = 0;
    set_in(0, 5'd0, 32'h0, 4'h0, 5'($urandom), 5'($urandom), 1);
    tick();
    bus.clr_req = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (!bus.clr_busy) break;
      busy_n++;
      if (c == reset_at) begin
        reset = 1'b1;
        model_reset();
        #1 chk("busy_at_reset", {31'b0, bus.clr_busy}, 32'h0);
        tick();
        reset = 1'b0;
        break;
      end
      // clr_req at cycle 5 must be ignored by the running clear.
      set_in(c == drop_at, 5'd9, 32'h0000DEAD, 4'hF, 5'($urandom), 5'($urandom), c == 5);
      tick();
      if (bus.clr_done) done_n++;
      if (bus.wr_drop)  drop_n++;
    end
  endtask

  int busy_n, done_n, drop_n;

  initial begin
    model_reset();
    // Reset held with a live write: reads must still be 0.
    set_in(1, 5'd5, 32'hFFFFFFFF, 4'hF, 5'd5, 5'd31, 0);
    @(negedge clk);
    repeat (3) tick();
    reset = 1'b0;
    set_in(0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd5, 0);  tick();
    set_in(0, 5'd0, 32'h0, 4'h0, 5'd31, 5'd0, 0); tick();
    set_in(0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd31, 0); tick();

    // Masked write.
    set_in(1, 5'd7, 32'hAABBCCDD, 4'hF, 5'd7, 5'd7, 0); tick();
    set_in(1, 5'd7, 32'h11223344, 4'h5, 5'd7, 5'd0, 0); tick();
    set_in(0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd7, 0);
    #1 chk("r7_masked", bus.rdata[31:0], 32'hAA22CC44);
    tick();

    // Bypass with the other port on r0.
    set_in(1, 5'd3, 32'h12345678, 4'hF, 5'd1, 5'd2, 0); tick();
    set_in(1, 5'd3, 32'hFFFFFFFF, 4'h3, 5'd3, 5'd0, 0);
    #1 chk("bypass_p0", bus.rdata[31:0], 32'h1234FFFF);
    chk("bypass_p1", bus.rdata[63:32], 32'h0);
    tick();

    // Random traffic.
    repeat (150) begin
      set_in(1'($urandom), 5'($urandom), $urandom, 4'($urandom),
             5'($urandom), 5'($urandom), 0);
      tick();
    end

    // Bulk clear with a dropped write at busy cycle 10.
    fill();
    run_clear(10, -1, busy_n, done_n, drop_n);
    chk("busy_cycles", 32'(busy_n), 32'd32);
    chk("done_pulses", 32'(done_n), 32'd1);
    chk("drop_pulses", 32'(drop_n), 32'd1);
    set_in(0, 5'd0, 32'h0, 4'h0, 5'd9, 5'd31, 0);
    #1 chk("r9_cleared", bus.rdata[31:0], 32'h0);
    tick();
    sweep();

    // Write and clear request in the same idle cycle.
    set_in(1, 5'd12, 32'hCAFEF00D, 4'hF, 5'd12, 5'd1, 1); tick();
    bus.clr_req = 1'b0;
    for (int c = 0; c < 100 && bus.clr_busy; c++) begin
      set_in(0, 5'd0, 32'h0, 4'h0, 5'd12, 5'($urandom), 0);
      tick();
    end
    sweep();

    // Reset in the middle of a clear, then a normal clear.
    fill();
    run_clear(-1, 15, busy_n, done_n, drop_n);
    done_n = 0;
    repeat (40) begin
      set_in(0, 5'd0, 32'h0, 4'h0, 5'($urandom), 5'($urandom), 0);
      tick();
      if (bus.clr_done) done_n++;
    end
    chk("no_done_after_reset", 32'(done_n), 32'd0);
    sweep();
    fill();
    run_clear(-1, -1, busy_n, done_n, drop_n);
    chk("busy_cycles2", 32'(busy_n), 32'd32);
    chk("done_pulses2", 32'(done_n), 32'd1);
    sweep();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised general-purpose register file for the CPU datapath. It generalises the earlier fixed 32x32, 2-read/1-write file to configurable width, depth and read-port count.
- Adds same-cycle write-to-read bypass, a write-enable byte mask, and a multi-cycle bulk-clear engine with a busy/done handshake.
- Sits between decode (read addresses) and writeback (write port).

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- NRD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = entry 0 hardwired to zero; 0 = entry 0 is an ordinary register.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- wbe  in  DATA_W/8  byte enables for the write.
- raddr  in  NRD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rdata  out  NRD*DATA_W  packed read data, combinational.
- clr_req  in  1  request to zero the whole file.
- clr_busy  out  1  clear engine active.
- clr_done  out  1  one-cycle pulse when the clear completes.
- wr_drop  out  1  one-cycle pulse: a write was discarded because a clear was in progress.

Behaviour:
- Reset (asynchronous, reset=1):
  - All entries go to 0.
  - FSM goes to IDLE and the clear pointer to 0.
  - clr_busy=0, clr_done=0, wr_drop=0.
  - rdata is 0 for every address while reset is held.
- Write, in IDLE:
  - On the rising edge with we=1, each byte i with wbe[i]=1 takes wdata[8i+7:8i]; the other bytes keep their old value.
  - Writes to entry 0 are discarded when ZERO_REG=1 (no wr_drop).
- Read, combinational:
  - rdata[k] = 0 when ZERO_REG=1 and raddr[k]==0.
  - Otherwise, if we=1, FSM is IDLE and raddr[k]==waddr, the bypass applies: the result is the masked merge (wdata bytes where wbe=1, stored bytes where wbe=0).
  - Otherwise rdata[k] is the stored entry.
  - All NRD ports are independent; any number of ports may read the same address.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on a rising edge with clr_req=1. The pointer loads 0 and clr_busy goes 1 from the next cycle.
  - CLEAR: one entry per cycle is written with 0 at the pointer, then the pointer increments.
  - When the pointer is DEPTH-1, that entry is cleared and the FSM returns to IDLE. clr_done pulses high for that one cycle after the edge, and clr_busy drops in the same cycle.
  - Total: DEPTH cycles with clr_busy=1.
  - clr_req while in CLEAR is ignored; it does not restart the pointer.
  - clr_req and we in the same IDLE cycle: the write is performed on that edge, then the clear starts (the write is subsequently zeroed).
  - In CLEAR, we=1 discards the write and pulses wr_drop the next cycle. No bypass is applied.
  - In CLEAR, all read ports return 0 regardless of address.
- Reset asserted mid-clear aborts immediately to the reset state. No clr_done is produced.
- Width rules: no arithmetic. The pointer is ADDR_W bits and its wrap at DEPTH-1 is the terminal condition, so no overflow occurs.

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- When defined:
  - Each entry stores one extra even-parity bit per byte, computed on write (including bypass-merged bytes) and set to 0 for cleared entries.
  - Extra output port par_err, NRD bits wide. par_err[k]=1 when the stored bytes read on port k fail parity.
  - par_err[k] is forced to 0 when bypass or zero-register applies, and 0 in reset and CLEAR.
- When not defined: no parity storage and no par_err port; behaviour is otherwise identical.

Test Plan:
- Reset then read: assert reset for 3 cycles, release, read addresses 0, 5 and 31 on all ports -> rdata = 0.
- Masked write: write 0xAABBCCDD to r7 with wbe=0xF, then write 0x11223344 to r7 with wbe=0x5 -> reading r7 returns 0xAA22CC44.
- Bypass with conflicting ports: with r3=0x12345678, in the same cycle set we=1, waddr=3, wdata=0xFFFFFFFF, wbe=0x3, port0 reads r3, port1 reads r0 -> port0 = 0x1234FFFF combinationally; port1 = 0 (ZERO_REG=1).
- Bulk clear: fill r1..r31 with nonzero values, pulse clr_req -> clr_busy high for exactly 32 cycles; clr_done pulses once; reads during the clear are 0; all entries are 0 afterwards.
- Write during clear: issue we=1 to r9 with 0xDEAD at clear cycle 10 -> wr_drop pulses once; r9 = 0 after clr_done.
- Reset mid-clear: assert reset at clear cycle 15 -> clr_busy=0 immediately; no clr_done; all entries 0. A new clr_req afterwards completes normally in 32 cycles.
